// File: rtl/response_encoder.sv
// rtl/response_encoder.sv - ASCII line serialiser for the UART debug link return path
// Emits "AA DDDDDDDD\n" for reads, "ok\n" for write acks and "halt\n" on a rising Irq.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module response_encoder #(
  parameter int HEX_UPPER = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Rsp_valid,
  output logic                  Rsp_ready,
  input  logic                  Rsp_is_read,
  input  logic [7:0]            Rsp_addr,
  input  logic [`WORD_SIZE-1:0] Rsp_data,
  input  logic                  Irq,
  output logic                  M_axis_tvalid,
  output logic [7:0]            M_axis_tdata,
  input  logic                  M_axis_tready
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_READ,
    SEND_OK,
    SEND_HALT
  } state_t;

  state_t                  state;
  logic [3:0]              byte_idx;
  logic [7:0]              addr_q;
  logic [`WORD_SIZE-1:0]   data_q;
  logic                    halt_pending;
  logic                    irq_d;
  logic                    halt_set;
  logic                    halt_done;
  logic                    last_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] alpha_base;
    alpha_base = (HEX_UPPER != 0) ? 8'h41 : 8'h61;
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = alpha_base + {4'h0, n} - 8'd10;
  endfunction

  // Bytes 3..10 walk the data word from its top nibble down.
  function automatic logic [7:0] read_byte(input logic [3:0]            idx,
                                           input logic [7:0]            addr,
                                           input logic [`WORD_SIZE-1:0] data);
    logic [5:0] shamt;
    shamt = {(4'd10 - idx), 2'b00};
    case (idx)
      4'd0:    read_byte = hex_char(addr[7:4]);
      4'd1:    read_byte = hex_char(addr[3:0]);
      4'd2:    read_byte = 8'h20;
      4'd11:   read_byte = 8'h0A;
      default: read_byte = hex_char(4'(data >> shamt));
    endcase
  endfunction

  function automatic logic [7:0] ok_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    ok_byte = 8'h6F;
      4'd1:    ok_byte = 8'h6B;
      default: ok_byte = 8'h0A;
    endcase
  endfunction

  function automatic logic [7:0] halt_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    halt_byte = 8'h68;
      4'd1:    halt_byte = 8'h61;
      4'd2:    halt_byte = 8'h6C;
      4'd3:    halt_byte = 8'h74;
      default: halt_byte = 8'h0A;
    endcase
  endfunction

  function automatic logic [3:0] last_idx(input state_t st);
    case (st)
      SEND_READ: last_idx = 4'd11;
      SEND_OK:   last_idx = 4'd2;
      SEND_HALT: last_idx = 4'd4;
      default:   last_idx = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] line_byte(input state_t                st,
                                           input logic [3:0]            idx,
                                           input logic [7:0]            addr,
                                           input logic [`WORD_SIZE-1:0] data);
    case (st)
      SEND_READ: line_byte = read_byte(idx, addr, data);
      SEND_OK:   line_byte = ok_byte(idx);
      SEND_HALT: line_byte = halt_byte(idx);
      default:   line_byte = 8'h00;
    endcase
  endfunction

  assign Rsp_ready = (state == IDLE) && !Rst;
  assign halt_set  = Irq && !irq_d;
  assign last_byte = (byte_idx == last_idx(state));
  assign halt_done = (state == SEND_HALT) && M_axis_tvalid && M_axis_tready && last_byte;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= IDLE;
      byte_idx      <= 4'd0;
      addr_q        <= 8'h00;
      data_q        <= '0;
      halt_pending  <= 1'b0;
      irq_d         <= 1'b1;
      M_axis_tvalid <= 1'b0;
      M_axis_tdata  <= 8'h00;
    end else begin
      irq_d <= Irq;
      // A new edge in the same cycle as the final halt byte keeps the request alive.
      halt_pending <= halt_set || (halt_pending && !halt_done);

      case (state)
        IDLE: begin
          byte_idx <= 4'd0;
          if (Rsp_valid && Rsp_ready) begin
            addr_q        <= Rsp_addr;
            data_q        <= Rsp_data;
            state         <= Rsp_is_read ? SEND_READ : SEND_OK;
            M_axis_tvalid <= 1'b1;
            M_axis_tdata  <= Rsp_is_read ? read_byte(4'd0, Rsp_addr, Rsp_data) : ok_byte(4'd0);
          end else if (halt_pending) begin
            state         <= SEND_HALT;
            M_axis_tvalid <= 1'b1;
            M_axis_tdata  <= halt_byte(4'd0);
          end
        end

        default: begin
          if (M_axis_tvalid && M_axis_tready) begin
            if (last_byte) begin
              state         <= IDLE;
              byte_idx      <= 4'd0;
              M_axis_tvalid <= 1'b0;
            end else begin
              byte_idx     <= byte_idx + 4'd1;
              M_axis_tdata <= line_byte(state, byte_idx + 4'd1, addr_q, data_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_encoder.sv
// tb/tb_response_encoder.sv - scoreboard bench for response_encoder, lower- and upper-case hex instances
// A line-level reference model queues expected bytes; a monitor pops them on each output handshake.
module tb_response_encoder;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Rsp_valid = 1'b0;
  logic        Rsp_is_read = 1'b0;
  logic [7:0]  Rsp_addr = 8'h00;
  logic [31:0] Rsp_data = 32'h0;
  logic        Irq = 1'b1;
  logic        M_axis_tready = 1'b1;

  logic        rsp_ready [2];
  logic        tvalid    [2];
  logic [7:0]  tdata     [2];

  int checks = 0;
  int errors = 0;

  bit         m_busy    [2] = '{0, 0};
  int         m_left    [2] = '{0, 0};
  bit         m_is_halt [2] = '{0, 0};
  bit         m_hpend   [2] = '{0, 0};
  bit         m_irq_d   [2] = '{1, 1};
  logic [7:0] exp_q     [2][$];
  int         acc_cnt   [2] = '{0, 0};
  int         hs_cnt    [2] = '{0, 0};
  string      out_str   [2];
  bit         prev_stall[2] = '{0, 0};
  logic [7:0] prev_data [2];

  always #5 Clk = ~Clk;

  function automatic string read_line(input bit upper, input logic [7:0] a, input logic [31:0] d);
    string s;
    s = $sformatf("%02h %08h\n", a, d);
    if (upper) s = s.toupper();
    return s;
  endfunction

  function automatic string vis(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else               r = {r, $sformatf("%c", s[i])};
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    response_encoder #(.HEX_UPPER(g)) u_dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Rsp_valid     (Rsp_valid),
      .Rsp_ready     (rsp_ready[g]),
      .Rsp_is_read   (Rsp_is_read),
      .Rsp_addr      (Rsp_addr),
      .Rsp_data      (Rsp_data),
      .Irq           (Irq),
      .M_axis_tvalid (tvalid[g]),
      .M_axis_tdata  (tdata[g]),
      .M_axis_tready (M_axis_tready)
    );

    // Reference model: predicts the effect of the coming rising edge from the inputs now applied.
    always @(negedge Clk) begin : model
      string line;
      checks++;
      if (tvalid[g] !== m_busy[g]) begin
        errors++;
        $display("FAIL tvalid[%0d]: got %b want %b at %0t", g, tvalid[g], m_busy[g], $time);
      end
      checks++;
      if (rsp_ready[g] !== (!m_busy[g] && !Rst)) begin
        errors++;
        $display("FAIL rsp_ready[%0d]: got %b want %b at %0t", g, rsp_ready[g], (!m_busy[g] && !Rst), $time);
      end
      if (Rst) begin
        m_busy[g]  = 0;
        m_left[g]  = 0;
        m_hpend[g] = 0;
        m_irq_d[g] = 1;
        exp_q[g].delete();
      end else begin
        if (!m_busy[g]) begin
          line = "";
          if (Rsp_valid) begin
            line = Rsp_is_read ? read_line(g == 1, Rsp_addr, Rsp_data) : "ok\n";
            m_is_halt[g] = 0;
            acc_cnt[g]++;
          end else if (m_hpend[g]) begin
            line = "halt\n";
            m_is_halt[g] = 1;
          end
          if (line.len() > 0) begin
            for (int i = 0; i < line.len(); i++) exp_q[g].push_back(line[i]);
            m_busy[g] = 1;
            m_left[g] = line.len();
          end
        end else if (M_axis_tready) begin
          m_left[g]--;
          if (m_left[g] == 0) begin
            m_busy[g] = 0;
            if (m_is_halt[g]) m_hpend[g] = 0;
          end
        end
        if (Irq && !m_irq_d[g]) m_hpend[g] = 1;
        m_irq_d[g] = Irq;
      end
    end

    always @(negedge Clk) begin : monitor
      logic [7:0] want;
      if (Rst) begin
        prev_stall[g] = 0;
      end else begin
        if (prev_stall[g]) begin
          checks++;
          if (tvalid[g] !== 1'b1 || tdata[g] !== prev_data[g]) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid=%b data=%02h want valid=1 data=%02h",
                     g, tvalid[g], tdata[g], prev_data[g]);
          end
        end
        if (tvalid[g] === 1'b1 && M_axis_tready) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte[%0d]: got %02h want no byte at %0t", g, tdata[g], $time);
          end else begin
            want = exp_q[g].pop_front();
            if (tdata[g] !== want) begin
              errors++;
              $display("FAIL byte[%0d]: got %02h want %02h at %0t", g, tdata[g], want, $time);
            end
          end
          hs_cnt[g]++;
          out_str[g] = {out_str[g], $sformatf("%c", tdata[g])};
        end
        prev_stall[g] = (tvalid[g] === 1'b1) && !M_axis_tready;
        prev_data[g]  = tdata[g];
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic chk_str(input string name, input int g, input string want);
    checks++;
    if (out_str[g] != want) begin
      errors++;
      $display("FAIL %s[%0d]: got \"%s\" want \"%s\"", name, g, vis(out_str[g]), vis(want));
    end
  endtask

  task automatic clear_out();
    for (int g = 0; g < 2; g++) begin
      out_str[g] = "";
      hs_cnt[g]  = 0;
    end
  endtask

  task automatic send(input bit rd, input logic [7:0] a, input logic [31:0] d);
    Rsp_valid   = 1'b1;
    Rsp_is_read = rd;
    Rsp_addr    = a;
    Rsp_data    = d;
    step();
    Rsp_valid   = 1'b0;
  endtask

  task automatic drain(input int budget, input bit toggle);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (toggle) M_axis_tready = ~M_axis_tready;
      done = !m_busy[0] && !m_busy[1] && !m_hpend[0] && !m_hpend[1] &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got lines outstanding want none after %0d cycles", budget);
    end
  endtask

  initial begin
    int a0;
    int hs_keep;

    // Reset with Irq already high: no halt line may follow.
    repeat (3) step();
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_tvalid[%0d]", g), 32'(tvalid[g]), 32'h0);
      chk($sformatf("reset_tdata[%0d]", g), 32'(tdata[g]), 32'h0);
      chk($sformatf("reset_rsp_ready[%0d]", g), 32'(rsp_ready[g]), 32'h0);
    end
    Rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) chk($sformatf("idle_rsp_ready[%0d]", g), 32'(rsp_ready[g]), 32'h1);
    clear_out();
    repeat (6) step();
    chk("irq_held_no_output", 32'(hs_cnt[0] + hs_cnt[1]), 32'h0);

    clear_out();
    send(1'b1, 8'h3C, 32'hDEADBEEF);
    drain(40, 1'b0);
    chk_str("read_line", 0, "3c deadbeef\n");
    chk_str("read_line", 1, "3C DEADBEEF\n");

    clear_out();
    M_axis_tready = 1'b1;
    send(1'b0, 8'h11, 32'h12345678);
    drain(40, 1'b1);
    M_axis_tready = 1'b1;
    chk_str("write_ack", 0, "ok\n");
    chk("write_ack_handshakes", 32'(hs_cnt[0]), 32'd3);

    clear_out();
    Irq = 1'b0;
    step();
    Irq = 1'b1;
    drain(40, 1'b0);
    chk_str("halt_line", 0, "halt\n");
    chk("halt_handshakes", 32'(hs_cnt[1]), 32'd5);

    // Halt edge during a read while a write ack is already waiting.
    clear_out();
    a0 = acc_cnt[0];
    Rsp_valid   = 1'b1;
    Rsp_is_read = 1'b1;
    Rsp_addr    = 8'hAF;
    Rsp_data    = 32'h0000000A;
    step();
    Rsp_is_read = 1'b0;
    Rsp_addr    = 8'h55;
    Rsp_data    = $urandom;
    step();
    Irq = 1'b0;
    step();
    Irq = 1'b1;
    for (int i = 0; i < 40 && acc_cnt[0] < a0 + 2; i++) step();
    Rsp_valid = 1'b0;
    drain(60, 1'b0);
    chk_str("read_ok_halt", 0, "af 0000000a\nok\nhalt\n");
    chk_str("read_ok_halt", 1, "AF 0000000A\nok\nhalt\n");

    // Reset part-way through a read line; the pending halt edge is dropped as well.
    clear_out();
    send(1'b1, 8'h12, 32'h34567890);
    Irq = 1'b0;
    step();
    Irq = 1'b1;
    for (int i = 0; i < 40 && hs_cnt[0] < 5; i++) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("abort_tvalid[%0d]", g), 32'(tvalid[g]), 32'h0);
      chk($sformatf("abort_rsp_ready[%0d]", g), 32'(rsp_ready[g]), 32'h1);
    end
    hs_keep = hs_cnt[0];
    repeat (20) step();
    chk("abort_no_more_bytes", 32'(hs_cnt[0]), 32'(hs_keep));
    chk_str("abort_prefix", 0, "12 34");

    // Randomised traffic, backpressure, Irq edges and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      Rst           = ($urandom_range(0, 399) == 0);
      Rsp_valid     = ($urandom_range(0, 3) == 0);
      Rsp_is_read   = $urandom_range(0, 1);
      Rsp_addr      = 8'($urandom);
      Rsp_data      = $urandom;
      M_axis_tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 24) == 0) Irq = ~Irq;
      step();
    end
    Rst           = 1'b0;
    Rsp_valid     = 1'b0;
    M_axis_tready = 1'b1;
    drain(300, 1'b0);
    chk("final_queue_empty", 32'(exp_q[0].size() + exp_q[1].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got no end of test want finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
